// File: rtl/mastermind_draw_pkg.sv
// mastermind_draw_pkg
//   Shared types and constants for the Mastermind board drawing blocks.
//   Holds the painter state enum, screen and peg geometry constants, the
//   erase colour, and a helper that picks one peg colour out of a packed
//   four-peg colour word.
package mastermind_draw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } draw_state_e;

  localparam int COLOUR_W     = 3;
  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int SQ_MEDIUM    = 10;
  localparam int SQ_BIG       = 20;
  localparam int PEGS_PER_ROW = 4;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

  // Colour of peg p; bits [3p+2:3p] of the packed word.
  function automatic logic [COLOUR_W-1:0] peg_colour(
    input logic [4*COLOUR_W-1:0] colours,
    input logic [1:0]            p
  );
    logic [COLOUR_W-1:0] c;
    case (p)
      2'd0:    c = colours[2:0];
      2'd1:    c = colours[5:3];
      2'd2:    c = colours[8:6];
      2'd3:    c = colours[11:9];
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/peg_pixel_counter.sv
// peg_pixel_counter
//   Walks the pixels of four SQ x SQ peg squares: peg index p, and within a
//   peg the pixel offset (dx, dy) in raster order with dx fastest.
//   Ports:
//     clock, resetn : clock and asynchronous active-low reset
//     clear         : synchronous return to p=0, dx=0, dy=0 (wins over enable)
//     enable        : advance one pixel per cycle
//     p, dx, dy     : current peg index and pixel offset
//     last          : high on the final pixel of the final peg
module peg_pixel_counter
  import mastermind_draw_pkg::*;
#(
  parameter int SQ = SQ_MEDIUM
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [1:0] p,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  logic [1:0] p_r;
  logic [3:0] dx_r;
  logic [3:0] dy_r;

  // Pixel/peg counter; q = dy*SQ + dx is kept as its two digits directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p_r  <= 2'd0;
      dx_r <= 4'd0;
      dy_r <= 4'd0;
    end else if (clear) begin
      p_r  <= 2'd0;
      dx_r <= 4'd0;
      dy_r <= 4'd0;
    end else if (enable) begin
      if (dx_r == 4'(SQ - 1)) begin
        dx_r <= 4'd0;
        if (dy_r == 4'(SQ - 1)) begin
          dy_r <= 4'd0;
          p_r  <= p_r + 2'd1;
        end else begin
          dy_r <= dy_r + 4'd1;
        end
      end else begin
        dx_r <= dx_r + 4'd1;
      end
    end else begin
      p_r  <= p_r;
      dx_r <= dx_r;
      dy_r <= dy_r;
    end
  end

  assign p    = p_r;
  assign dx   = dx_r;
  assign dy   = dy_r;
  assign last = (p_r == 2'(PEGS_PER_ROW - 1)) &&
                (dx_r == 4'(SQ - 1)) && (dy_r == 4'(SQ - 1));

endmodule

// File: rtl/guess_row_painter.sv
// guess_row_painter
//   Paints one guess row (four pegs, each an SQ x SQ square) into the VGA
//   framebuffer as a burst of 4*SQ*SQ single-pixel writes.
//   Ports:
//     clock, resetn        : clock and asynchronous active-low reset
//     start, row, colours  : request from the game controller; accepted in IDLE
//     busy, done           : handshake back to the controller
//     vga_x, vga_y         : absolute framebuffer coordinate
//     vga_colour, plot     : pixel colour and write enable to the VGA adapter
//   Build option: define MASTERMIND_PEG_OUTLINE_EN to draw a 1-pixel black
//   outline around every peg (interior keeps the peg colour).
module guess_row_painter
  import mastermind_draw_pkg::*;
#(
  parameter int X_ORIGIN  = 10,
  parameter int Y_ORIGIN  = 5,
  parameter int PEG_PITCH = 20,
  parameter int ROW_PITCH = 11,
  parameter int SQ        = SQ_MEDIUM,
  parameter int NUM_ROWS  = 10
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [3:0]          row,
  input  logic [11:0]         colours,
  output logic                busy,
  output logic                done,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot
);

  draw_state_e         state_r, next_state_s;
  logic [3:0]          row_r;
  logic [11:0]         colours_r;
  logic                accept_s;
  logic                row_ok_s;
  logic [1:0]          p_s;
  logic [3:0]          dx_s, dy_s;
  logic                last_s;
  logic [COLOUR_W-1:0] pix_colour_s;

  logic                busy_s, done_s, plot_s;
  logic [7:0]          x_s;
  logic [6:0]          y_s;
  logic [COLOUR_W-1:0] colour_s;
  logic                busy_r, done_r, plot_r;
  logic [7:0]          x_r;
  logic [6:0]          y_r;
  logic [COLOUR_W-1:0] colour_r;

  assign accept_s = (state_r == IDLE) && start;
  assign row_ok_s = (row < 4'(NUM_ROWS));

  peg_pixel_counter #(.SQ(SQ)) u_counter (
    .clock  (clock),
    .resetn (resetn),
    .clear  (accept_s),
    .enable (state_r == DRAW),
    .p      (p_s),
    .dx     (dx_s),
    .dy     (dy_s),
    .last   (last_s)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; out-of-range rows skip straight to FINISH.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (row_ok_s) next_state_s = DRAW;
          else          next_state_s = FINISH;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRAW: begin
        if (last_s) next_state_s = FINISH;
        else        next_state_s = DRAW;
      end
      FINISH:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch so row/colour changes after acceptance are ignored.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      row_r     <= 4'd0;
      colours_r <= 12'd0;
    end else if (accept_s && row_ok_s) begin
      row_r     <= row;
      colours_r <= colours;
    end else begin
      row_r     <= row_r;
      colours_r <= colours_r;
    end
  end

  // Pixel colour, optionally forced to black on the peg border.
  always_comb begin
    pix_colour_s = peg_colour(colours_r, p_s);
`ifdef MASTERMIND_PEG_OUTLINE_EN
    if ((dx_s == 4'd0) || (dx_s == 4'(SQ - 1)) ||
        (dy_s == 4'd0) || (dy_s == 4'(SQ - 1))) begin
      pix_colour_s = BLACK;
    end else begin
      pix_colour_s = peg_colour(colours_r, p_s);
    end
`endif
  end

  // Output next-values; outputs lag the state by one register stage, and
  // the coordinate is summed at 9 bits then truncated to the port width.
  always_comb begin
    busy_s   = (next_state_s != IDLE);
    done_s   = (state_r == FINISH);
    plot_s   = (state_r == DRAW);
    x_s      = x_r;
    y_s      = y_r;
    colour_s = colour_r;
    if (state_r == DRAW) begin
      x_s      = 8'(9'(X_ORIGIN) + 9'(p_s) * 9'(PEG_PITCH) + 9'(dx_s));
      y_s      = 7'(9'(Y_ORIGIN) + 9'(row_r) * 9'(ROW_PITCH) + 9'(dy_s));
      colour_s = pix_colour_s;
    end else begin
      x_s      = x_r;
      y_s      = y_r;
      colour_s = colour_r;
    end
  end

  // Output registers; reset clears them without waiting for a clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      plot_r   <= 1'b0;
      x_r      <= 8'd0;
      y_r      <= 7'd0;
      colour_r <= BLACK;
    end else begin
      busy_r   <= busy_s;
      done_r   <= done_s;
      plot_r   <= plot_s;
      x_r      <= x_s;
      y_r      <= y_s;
      colour_r <= colour_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign plot       = plot_r;
  assign vga_x      = x_r;
  assign vga_y      = y_r;
  assign vga_colour = colour_r;

endmodule

// File: tb/tb_guess_row_painter.sv
module tb_guess_row_painter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  row;
  logic [11:0] colours;
  logic        busy, done, plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  always #5 clock = ~clock;

  guess_row_painter dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .row        (row),
    .colours    (colours),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  localparam int NCAP = 410;
  logic       plot_a [NCAP];
  logic       done_a [NCAP];
  logic       busy_a [NCAP];
  logic [7:0] x_a    [NCAP];
  logic [6:0] y_a    [NCAP];
  logic [2:0] col_a  [NCAP];
  int cap_n;

  int n_cmp = 0;
  int n_fail = 0;
  int plot_cnt, done_cnt, done_idx, pix_bad, max_x, max_y, col0_cnt, col7_cnt;
  bit outline_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns right after the accepting edge.
  task automatic start_req(input logic [3:0] r, input logic [11:0] c);
    @(negedge clock);
    start = 1'b1;
    row = r;
    colours = c;
    @(posedge clock);
  endtask

  // Sample n cycles after the accepting edge; index i = cycle after edge E+i.
  task automatic capture(input int n, input int pulse_at, input logic [3:0] r2, input logic [11:0] c2);
    cap_n = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      if (i == pulse_at) begin
        start = 1'b1;
        row = r2;
        colours = c2;
      end else if (i == pulse_at + 1) begin
        start = 1'b0;
      end
      plot_a[i] = plot;
      done_a[i] = done;
      busy_a[i] = busy;
      x_a[i]    = vga_x;
      y_a[i]    = vga_y;
      col_a[i]  = vga_colour;
    end
  endtask

  task automatic stats();
    plot_cnt = 0; done_cnt = 0; done_idx = -1; max_x = 0; max_y = 0;
    col0_cnt = 0; col7_cnt = 0;
    for (int i = 0; i < cap_n; i++) begin
      if (plot_a[i]) begin
        plot_cnt++;
        if (int'(x_a[i]) > max_x) max_x = int'(x_a[i]);
        if (int'(y_a[i]) > max_y) max_y = int'(y_a[i]);
        if (col_a[i] == 3'd0) col0_cnt++;
        if (col_a[i] == 3'd7) col7_cnt++;
      end
      if (done_a[i]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
  endtask

  // Reference pixel stream: pixel k is expected at capture index k+1.
  task automatic model_check(input int r, input logic [11:0] c);
    int p, q, dx, dy, ex, ey, ec;
    pix_bad = 0;
    for (int k = 0; k < 400; k++) begin
      p = k / 100; q = k % 100; dx = q % 10; dy = q / 10;
      ex = 10 + 20 * p + dx;
      ey = 5 + 11 * r + dy;
      ec = int'((c >> (3 * p)) & 12'd7);
      if (outline_en && (dx == 0 || dx == 9 || dy == 0 || dy == 9)) ec = 0;
      if (plot_a[k + 1] !== 1'b1 || int'(x_a[k + 1]) != ex ||
          int'(y_a[k + 1]) != ey || int'(col_a[k + 1]) != ec) pix_bad++;
    end
  endtask

  initial begin
`ifdef MASTERMIND_PEG_OUTLINE_EN
    outline_en = 1'b1;
`else
    outline_en = 1'b0;
`endif
    resetn = 1'b0; start = 1'b0; row = 4'd0; colours = 12'd0;
    #12;
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_col", vga_colour, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Row 0, colours 7421.
    start_req(4'd0, 12'o7421);
    capture(405, -1, 4'd0, 12'd0);
    stats();
    model_check(0, 12'o7421);
    check("t1_plot_cnt", plot_cnt, 400);
    check("t1_plot_idx0", plot_a[0], 0);
    check("t1_p0_x", x_a[1], 10);
    check("t1_p0_y", y_a[1], 5);
    check("t1_p0_col", col_a[1], outline_en ? 0 : 1);
    check("t1_p100_x", x_a[101], 30);
    check("t1_p100_y", y_a[101], 5);
    check("t1_p100_col", col_a[101], outline_en ? 0 : 2);
    check("t1_p399_x", x_a[400], 79);
    check("t1_p399_y", y_a[400], 14);
    check("t1_p399_col", col_a[400], outline_en ? 0 : 7);
    check("t1_done_idx", done_idx, 401);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_first", busy_a[0], 1);
    check("t1_busy_last_plot", busy_a[400], 1);
    check("t1_busy_at_done", busy_a[401], 0);
    check("t1_hold_x", x_a[402], 79);
    check("t1_pix_bad", pix_bad, 0);

    // Row 9, bottom of the board.
    start_req(4'd9, 12'o0356);
    capture(405, -1, 4'd0, 12'd0);
    stats();
    model_check(9, 12'o0356);
    check("t2_first_y", y_a[1], 104);
    check("t2_last_y", y_a[400], 113);
    check("t2_last_col", col_a[400], 0);
    check("t2_x_in_screen", max_x < 160, 1);
    check("t2_y_in_screen", max_y < 120, 1);
    check("t2_pix_bad", pix_bad, 0);

    // Row 12 is rejected.
    start_req(4'd12, 12'o7777);
    capture(6, -1, 4'd0, 12'd0);
    stats();
    check("t3_plot_cnt", plot_cnt, 0);
    check("t3_done0", done_a[0], 0);
    check("t3_done1", done_a[1], 1);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_busy0", busy_a[0], 1);
    check("t3_busy1", busy_a[1], 0);

    // Row 3 with a second start and new inputs mid-draw.
    start_req(4'd3, 12'o1234);
    capture(405, 50, 4'd5, 12'o7777);
    stats();
    model_check(3, 12'o1234);
    check("t4_plot_cnt", plot_cnt, 400);
    check("t4_first_y", y_a[1], 38);
    check("t4_last_y", y_a[400], 47);
    check("t4_max_y", max_y, 47);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_pix_bad", pix_bad, 0);

    // Reset while pixel 150 is presented.
    start_req(4'd1, 12'o3333);
    capture(152, -1, 4'd0, 12'd0);
    check("t5_plot_before_rst", plot_a[151], 1);
    resetn = 1'b0;
    #1;
    check("t5_rst_plot", plot, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_x", vga_x, 0);
    @(negedge clock);
    resetn = 1'b1;
    start_req(4'd2, 12'o5555);
    capture(405, -1, 4'd0, 12'd0);
    stats();
    model_check(2, 12'o5555);
    check("t5_plot_cnt", plot_cnt, 400);
    check("t5_first_x", x_a[1], 10);
    check("t5_first_y", y_a[1], 27);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_pix_bad", pix_bad, 0);

    // All pegs colour 7: outline count depends on build option.
    start_req(4'd1, 12'o7777);
    capture(405, -1, 4'd0, 12'd0);
    stats();
    check("t6_col0_cnt", col0_cnt, outline_en ? 144 : 0);
    check("t6_col7_cnt", col7_cnt, outline_en ? 256 : 400);
    check("t6_plot_cnt", plot_cnt, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
